lbp_seg_encoder: RTL and testbench
==================================

// Module: lbp_seg_encoder
// PURPOSE
//  Parametrised sequential leading-one (LBP) encoder for the ODPC datapath.
//  Accepts a DATA_W-bit word over a valid/ready handshake. Scans it MSB-first in SEG_W-bit segments, one segment per clock,
//  and stops at the first segment that contains a one.
//  Returns code {pos,1'b0}, where pos is the index of the highest set bit. An all-zero word returns {POS_W'b0,1'b1}.
//  At DATA_W=SEG_W=8 the mapping equals the 8-bit combinational LBP encoder.
// PARAMETERS
//  DATA_W  32  input word width; must be an integer multiple of SEG_W, >=2
//  SEG_W    8  bits examined per SCAN cycle
//  (derived) NSEG=DATA_W/SEG_W, POS_W=$clog2(DATA_W), SEG_CW=max(1,$clog2(NSEG))
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input word valid
//  in_ready   out  1        block can take a word this cycle
//  in_data    in   DATA_W   word to encode; bit DATA_W-1 has highest priority
//  out_valid  out  1        result valid; held until taken
//  out_ready  in   1        downstream accepts result
//  out_code   out  POS_W+1  {pos,1'b0} on a hit; {0,1'b1} when the word is all zero
// BEHAVIOUR
//  - Clocking: one clock (clk). Reset rst_n is asynchronous, active-low.
//  - Reset: state=IDLE, out_valid=0, out_code=0, seg counter=NSEG-1, data reg=0.
//    Handshakes while rst_n=0 are ignored.
//  - A reset in any state aborts the word in flight; no result is produced for it.
//  - States:
//    IDLE: in_ready=1. On in_valid: capture in_data, set seg=NSEG-1, go to SCAN.
//    SCAN: in_ready=0; examine data[seg*SEG_W +: SEG_W].
//      - Segment non-zero: out_code<={seg*SEG_W+lz_idx,1'b0}; go to DONE. lz_idx is the index of the highest set bit within the segment.
//      - Segment zero and seg==0: out_code<={0,1'b1}; go to DONE.
//      - Otherwise: seg<=seg-1; stay in SCAN.
//    DONE: out_valid=1; out_code held stable.
//      - in_ready=out_ready, so a new word can be taken on the same edge the result is taken.
//      - On out_ready & in_valid: capture the new word, go to SCAN.
//      - On out_ready & !in_valid: go to IDLE.
//  - Latency: k cycles from the accept edge to out_valid=1, where k = number of segments scanned (1..NSEG).
//  - out_valid is a register. It rises on the edge leaving SCAN and falls on the edge where out_ready=1.
//  - Throughput: back-to-back words take k+1 cycles each.
//  - pos arithmetic: seg*SEG_W+lz_idx computed at POS_W bits, no overflow by construction.
//  - Within a segment, the highest-index set bit wins; lower set bits are don't-care.
//  - in_data may change freely while in_ready=0; only the captured copy is scanned.
// CONFIGURATION
//  LBP_PARITY_EN defined:
//   - Adds ports in_par (in, 1; even parity over in_data) and out_perr (out, 1; reset 0).
//   - Parity is checked at capture; out_perr is registered with out_code and is valid while out_valid=1.
//   - out_code is still computed normally on a parity error.
//  LBP_PARITY_EN undefined: no parity ports and no checking logic.
// TESTING  (DATA_W=32, SEG_W=8, out_ready=1 unless stated)
//  1 in_data=32'h8000_0000 -> out_code=6'b111110, k=1.
//  2 in_data=32'h0010_0400 -> out_code=6'b101000 (pos 20), k=2.
//  3 in_data=32'h0000_0001 -> out_code=6'b000000, k=4; in_data=0 -> 6'b000001, k=4.
//  4 out_ready=0 for 5 cycles in DONE -> out_valid=1, out_code stable, in_ready=0.
//    Then out_ready=1, in_valid=1, in_data=32'h0000_0100 -> accepted on the same edge -> out_code=6'b010000.
//  5 rst_n=0 during SCAN of 32'h0000_00FF -> out_valid=0, IDLE, no result.
//    Next word 32'h4000_0000 -> out_code=6'b111100.
//  6 LBP_PARITY_EN: in_data=1, in_par=0 -> out_perr=1, out_code=0; in_par=1 -> out_perr=0.
//    Build without the macro must elaborate with no parity ports.

Source files
------------

// File: rtl/lbp_seg_encoder.sv
// rtl/lbp_seg_encoder.sv - sequential segment-scanning leading-one (LBP) encoder
//
// Purpose:
//   Takes a DATA_W-bit word over a valid/ready handshake. It scans the word
//   MSB-first in SEG_W-bit segments, one segment per clock, and stops at the
//   first segment that holds a one. The result is {pos,1'b0}, where pos is the
//   index of the highest set bit. An all-zero word gives {0,1'b1}.
//
// Optional feature macro: LBP_PARITY_EN
//   When defined, adds in_par and out_perr. in_par is even parity over in_data.
//   Parity is checked when the word is captured. out_perr is valid with out_code.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        input word valid
//   in_ready   out  1        block can take a word this cycle
//   in_data    in   DATA_W   word to encode, MSB has highest priority
//   out_valid  out  1        result valid, held until taken
//   out_ready  in   1        downstream accepts result
//   out_code   out  POS_W+1  {pos,1'b0} on a hit, {0,1'b1} for an all-zero word
//   in_par     in   1        (LBP_PARITY_EN) even parity over in_data
//   out_perr   out  1        (LBP_PARITY_EN) parity error of the encoded word

module lbp_seg_encoder #(
  parameter int DATA_W = 32,
  parameter int SEG_W  = 8,
  localparam int NSEG   = DATA_W / SEG_W,
  localparam int POS_W  = $clog2(DATA_W),
  localparam int SEG_CW = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [POS_W:0]    out_code
`ifdef LBP_PARITY_EN
  ,
  input  logic              in_par,
  output logic              out_perr
`endif
);

  localparam int LZ_W = (SEG_W > 1) ? $clog2(SEG_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_data;
  logic [SEG_CW-1:0]   r_seg;
  logic [POS_W:0]      r_code;
  logic                r_valid;

  logic                w_accept;
  logic [SEG_W-1:0]    w_seg_bits;
  logic                w_hit;
  logic                w_last_seg;
  logic                w_finish;
  logic [LZ_W-1:0]     w_lz;
  logic [POS_W-1:0]    w_pos;

  assign w_accept   = in_valid & in_ready;
  assign w_seg_bits = r_data[r_seg*SEG_W +: SEG_W];
  assign w_hit      = |w_seg_bits;
  assign w_last_seg = (r_seg == '0);
  assign w_finish   = (r_state == SCAN) && (w_hit || w_last_seg);

  // Highest set bit within the current segment. Later iterations override
  // earlier ones, so the top-most one wins.
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < SEG_W; i++) begin
      if (w_seg_bits[i]) w_lz = LZ_W'(i);
    end
  end

  // Arithmetic is modulo 2**POS_W. The true value is always below DATA_W,
  // so the result cannot wrap.
  assign w_pos = POS_W'(r_seg) * POS_W'(SEG_W) + POS_W'(w_lz);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = SCAN;
      SCAN: if (w_hit || w_last_seg) w_next = DONE;
      DONE: if (out_ready) w_next = in_valid ? SCAN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic. In DONE, the result and the next word share one edge.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_seg   <= SEG_CW'(NSEG - 1);
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data <= in_data;
        r_seg  <= SEG_CW'(NSEG - 1);
      end else if (r_state == SCAN && !w_hit && !w_last_seg) begin
        r_seg <= r_seg - 1'b1;
      end

      if (w_finish) begin
        r_code  <= w_hit ? {w_pos, 1'b0} : {{POS_W{1'b0}}, 1'b1};
        r_valid <= 1'b1;
      end else if (r_state == DONE && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_code  = r_code;

`ifdef LBP_PARITY_EN
  logic r_perr_cap;
  logic r_perr;

  // The error flag is captured with the word. It is published with the code,
  // so out_perr keeps its value while a new word is scanned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr_cap <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      if (w_accept) r_perr_cap <= ^{in_data, in_par};
      if (w_finish) r_perr     <= r_perr_cap;
    end
  end

  assign out_perr = r_perr;
`endif

endmodule

// File: tb/tb_lbp_seg_encoder.sv
// tb/tb_lbp_seg_encoder.sv - directed self-checking bench for lbp_seg_encoder
module tb_lbp_seg_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_code;
`ifdef LBP_PARITY_EN
  logic        in_par;
  logic        out_perr;
`endif
  logic        par_flip;

  int total;
  int bad;
  int cycles;
  logic [5:0] held_code;

  lbp_seg_encoder #(.DATA_W(32), .SEG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code)
`ifdef LBP_PARITY_EN
    ,
    .in_par    (in_par),
    .out_perr  (out_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid, counting edges after the accept edge.
  task automatic wait_result();
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Present a word (block must be ready), then check latency and code.
  task automatic run_word(input string tag, input logic [31:0] data,
                          input logic [5:0] exp_code, input int exp_k);
    @(negedge clk);
    in_data  = data;
    in_valid = 1'b1;
`ifdef LBP_PARITY_EN
    in_par   = (^data) ^ par_flip;
`endif
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~data;
    wait_result();
    check({tag, "_k"}, cycles, exp_k);
    check({tag, "_code"}, {26'b0, out_code}, {26'b0, exp_code});
`ifdef LBP_PARITY_EN
    check({tag, "_perr"}, {31'b0, out_perr}, {31'b0, par_flip});
`endif
    @(posedge clk); #1;
    check({tag, "_vfall"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    par_flip  = 1'b0;
`ifdef LBP_PARITY_EN
    in_par    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_code", {26'b0, out_code}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_word("t1_msb", 32'h8000_0000, 6'b111110, 1);
    run_word("t2_pos20", 32'h0010_0400, 6'b101000, 2);
    run_word("t3_lsb", 32'h0000_0001, 6'b000000, 4);
    run_word("t3_zero", 32'h0000_0000, 6'b000001, 4);
    run_word("seg1_top", 32'h0000_FF00, 6'b011110, 3);

    // Result held under back-pressure, then a new word taken on the same edge.
    out_ready = 1'b0;
    @(negedge clk);
    in_data  = 32'h8000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result();
    check("t4_k", cycles, 1);
    held_code = out_code;
    check("t4_code", {26'b0, held_code}, {26'b0, 6'b111110});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_hold_v", {31'b0, out_valid}, 32'd1);
      check("t4_hold_c", {26'b0, out_code}, {26'b0, held_code});
      check("t4_hold_rdy", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0100;
    #1;
    check("t4_same_rdy", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    check("t4_vfall", {31'b0, out_valid}, 32'd0);
    check("t4_scan_rdy", {31'b0, in_ready}, 32'd0);
    wait_result();
    check("t4b_k", cycles, 3);
    check("t4b_code", {26'b0, out_code}, {26'b0, 6'b010000});
    @(posedge clk); #1;

    // Reset during SCAN aborts the word.
    @(negedge clk);
    in_data  = 32'h0000_00FF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t5_rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t5_no_result", {31'b0, out_valid}, 32'd0);
    end
    run_word("t5_next", 32'h4000_0000, 6'b111100, 1);

`ifdef LBP_PARITY_EN
    par_flip = 1'b1;
    run_word("t6_perr", 32'h0000_0001, 6'b000000, 4);
    par_flip = 1'b0;
    run_word("t6_pok", 32'h0000_0001, 6'b000000, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
